packet_flitizer: RTL and testbench

//  Downstream stage of the packet data generator: accepts whole PKT_W-bit packets over a

---
 rtl/noc_pkg.sv | 18 +
 rtl/packet_flitizer_if.sv | 29 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/packet_flitizer.sv | 119 +++++++++++
 tb/tb_packet_flitizer.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared types and defaults for the packet-to-flit serializer.
package noc_pkg;

  typedef enum logic [1:0] {
    FT_BODY = 2'b00,
    FT_HEAD = 2'b01,
    FT_TAIL = 2'b10
  } flit_type_e;

  localparam int PKT_W_DEF  = 57;
  localparam int FLIT_W_DEF = 19;
  localparam int DEPTH_DEF  = 4;

  function automatic int nflits(input int pktW, input int flitW);
    return (pktW + flitW - 1) / flitW;
  endfunction

endpackage

// File: rtl/packet_flitizer_if.sv
// Packet-in / flit-out handshake bundle plus status outputs of the flitizer.
interface packet_flitizer_if
  import noc_pkg::*;
#(
  parameter int PKT_W  = PKT_W_DEF,
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
);
  logic                         in_valid;
  logic                         in_ready;
  logic [PKT_W-1:0]             in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [FLIT_W-1:0]            out_flit;
  logic [1:0]                   out_type;
  logic [$clog2(DEPTH+1)-1:0]   fifo_count;
  logic                         busy;

  // master: packet source + router sink; slave: the flitizer itself
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_flit, out_type, fifo_count, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_flit, out_type, fifo_count, busy
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; read data is the current head entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wrData,
  output logic [WIDTH-1:0]           rdData,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic             doPush, doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign rdData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= nextPtr(wrPtr);
      if (doPop)  rdPtr <= nextPtr(rdPtr);
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/packet_flitizer.sv
// Buffers whole packets and serializes each one into HEAD/BODY.../TAIL flits.
//  state | meaning
//  IDLE  | serializer empty, waiting for a buffered packet
//  SEND  | presenting flit idx of the held packet to the router
module packet_flitizer
  import noc_pkg::*;
#(
  parameter int PKT_W  = PKT_W_DEF,
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  packet_flitizer_if.slave   bus
);
  localparam int NFLITS = nflits(PKT_W, FLIT_W);
  localparam int IDX_W  = $clog2(NFLITS);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int PAD_W  = NFLITS * FLIT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFLITS-1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e            state, stateNxt;
  logic [IDX_W-1:0]  idx, idxNxt;
  logic [PAD_W-1:0]  pktHold, pktNxt;
  logic [FLIT_W-1:0] flitQ, flitNxt;
  flit_type_e        typeQ, typeNxt;
  logic              inReadyQ;
  logic              push, pop, load;
  logic [PKT_W-1:0]  fifoHead;
  logic [CNT_W-1:0]  fifoCount, cntNxt;
  logic              fifoFull, fifoEmpty;

  function automatic logic [FLIT_W-1:0] flitSel(input logic [PAD_W-1:0] p,
                                                input logic [IDX_W-1:0] k);
    logic [FLIT_W-1:0] r;
    r = '0;
    for (int i = 0; i < NFLITS; i++)
      if (k == IDX_W'(i)) r = p[i*FLIT_W +: FLIT_W];
    return r;
  endfunction

  sync_fifo #(.WIDTH(PKT_W), .DEPTH(DEPTH)) uFifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .wrData (bus.in_data),
    .rdData (fifoHead),
    .count  (fifoCount),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  assign push   = bus.in_valid && inReadyQ && !fifoFull;
  assign cntNxt = fifoCount + CNT_W'(push) - CNT_W'(pop);

  // in_ready is registered from the post-edge occupancy, so a pop never frees a slot the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inReadyQ <= 1'b0;
    else        inReadyQ <= (cntNxt != CNT_W'(DEPTH));
  end

  always_comb begin
    stateNxt = state;
    idxNxt   = idx;
    pktNxt   = pktHold;
    load     = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE: load = !fifoEmpty;
      SEND: begin
        if (bus.out_ready) begin
          if (idx != LAST_IDX) idxNxt = idx + 1'b1;
          else if (!fifoEmpty) load = 1'b1;
          else                 stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
    if (load) begin
      pktNxt   = PAD_W'(fifoHead);
      idxNxt   = '0;
      stateNxt = SEND;
      pop      = 1'b1;
    end
    flitNxt = '0;
    typeNxt = FT_BODY;
    if (stateNxt == SEND) begin
      flitNxt = flitSel(pktNxt, idxNxt);
      if (idxNxt == '0)            typeNxt = FT_HEAD;
      else if (idxNxt == LAST_IDX) typeNxt = FT_TAIL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      pktHold <= '0;
      flitQ   <= '0;
      typeQ   <= FT_BODY;
    end else begin
      state   <= stateNxt;
      idx     <= idxNxt;
      pktHold <= pktNxt;
      flitQ   <= flitNxt;
      typeQ   <= typeNxt;
    end
  end

  assign bus.in_ready   = inReadyQ;
  assign bus.out_valid  = (state == SEND);
  assign bus.busy       = (state == SEND);
  assign bus.out_flit   = flitQ;
  assign bus.out_type   = typeQ;
  assign bus.fifo_count = fifoCount;
endmodule

// File: tb/tb_packet_flitizer.sv
// Directed and randomized checks of packet_flitizer with 57-bit packets and 19-bit flits.
module tb_packet_flitizer;
  import noc_pkg::*;

  localparam int PKT_W  = 57;
  localparam int FLIT_W = 19;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  packet_flitizer_if #(.PKT_W(PKT_W), .FLIT_W(FLIT_W), .DEPTH(DEPTH)) bus ();

  packet_flitizer #(.PKT_W(PKT_W), .FLIT_W(FLIT_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    outs = {bus.in_ready, bus.out_valid, bus.out_flit, bus.out_type, bus.fifo_count, bus.busy};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", outs); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_before_edge got %b exp 0", bus.in_ready); end
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after_edge got %b exp 1", bus.in_ready); end
    // load serializer + 2 FIFO entries, then reset asynchronously
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 57'h0_0000_0000_0777;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.fifo_count !== 3'd2 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL reset_prefill got count %0d valid %b exp 2 1", bus.fifo_count, bus.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    outs = {bus.in_ready, bus.out_valid, bus.out_flit, bus.out_type, bus.fifo_count, bus.busy};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_midrun_outputs got %h exp 0", outs); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.fifo_count !== 3'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release got rdy %b cnt %0d vld %b exp 1 0 0", bus.in_ready, bus.fifo_count, bus.out_valid);
    end
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 57'h1_2345_6789_ABCD;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.fifo_count !== 3'd1) begin
      errors++; $display("FAIL single_accept got vld %b cnt %0d exp 0 1", bus.out_valid, bus.fifo_count);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_type !== 2'b01 || bus.out_flit !== 19'h1ABCD || bus.busy !== 1'b1) begin
      errors++; $display("FAIL single_head got vld %b type %b flit %h busy %b exp 1 01 1abcd 1",
                         bus.out_valid, bus.out_type, bus.out_flit, bus.busy);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_type !== 2'b00 || bus.out_flit !== 19'h0ACF1) begin
      errors++; $display("FAIL single_body got vld %b type %b flit %h exp 1 00 0acf1", bus.out_valid, bus.out_type, bus.out_flit);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_type !== 2'b10 || bus.out_flit !== 19'h0048D) begin
      errors++; $display("FAIL single_tail got vld %b type %b flit %h exp 1 10 0048d", bus.out_valid, bus.out_type, bus.out_flit);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_type !== 2'b00 || bus.out_flit !== '0) begin
      errors++; $display("FAIL single_idle got vld %b busy %b type %b flit %h exp 0 0 00 0",
                         bus.out_valid, bus.busy, bus.out_type, bus.out_flit);
    end
  endtask

  task automatic test_back_to_back();
    logic [PKT_W-1:0]  pk  [4];
    logic [FLIT_W-1:0] exp [12];
    logic [1:0]        expT;
    int sent, n;
    bit started;
    pk[0] = {19'h00003, 19'h00002, 19'h00001};
    pk[1] = {19'h7FFFF, 19'h55555, 19'h2AAAA};
    pk[2] = {19'h00C0D, 19'h00A0B, 19'h00809};
    pk[3] = {19'h12345, 19'h6789A, 19'h0BCDE};
    exp = '{19'h00001, 19'h00002, 19'h00003, 19'h2AAAA, 19'h55555, 19'h7FFFF,
            19'h00809, 19'h00A0B, 19'h00C0D, 19'h0BCDE, 19'h6789A, 19'h12345};
    sent = 0; n = 0; started = 0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && n < 12; cyc++) begin
      bus.in_valid = (sent < 4);
      bus.in_data  = (sent < 4) ? pk[sent] : '0;
      if (bus.out_valid) started = 1;
      if (started) begin
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_bubble at flit %0d got vld 0 exp 1", n); end
      end
      if (bus.out_valid && bus.out_ready) begin
        expT = (n % 3 == 0) ? 2'b01 : (n % 3 == 2) ? 2'b10 : 2'b00;
        checks++;
        if (bus.out_flit !== exp[n] || bus.out_type !== expT) begin
          errors++; $display("FAIL b2b_flit%0d got %h/%b exp %h/%b", n, bus.out_flit, bus.out_type, exp[n], expT);
        end
        n++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (n != 12) begin errors++; $display("FAIL b2b_count got %0d exp 12", n); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got vld %b exp 0", bus.out_valid); end
  endtask

  task automatic test_stall();
    logic [PKT_W-1:0] s [5];
    logic [1:0] expT;
    int sent, n;
    for (int i = 0; i < 5; i++)
      s[i] = {19'(3*i + 'h103), 19'(3*i + 'h102), 19'(3*i + 'h101)};
    sent = 0;
    bus.out_ready = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      bus.in_valid = (sent < 5);
      bus.in_data  = (sent < 5) ? s[sent] : '0;
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
      if (cyc >= 1) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_type !== 2'b01 || bus.out_flit !== 19'h00101) begin
          errors++; $display("FAIL stall_hold cyc %0d got %b/%b/%h exp 1/01/00101", cyc, bus.out_valid, bus.out_type, bus.out_flit);
        end
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.fifo_count !== 3'd4 || bus.in_ready !== 1'b0 || sent != 5) begin
      errors++; $display("FAIL stall_full got cnt %0d rdy %b sent %0d exp 4 0 5", bus.fifo_count, bus.in_ready, sent);
    end
    bus.out_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 15; cyc++) begin
      if (bus.out_valid) begin
        expT = (n % 3 == 0) ? 2'b01 : (n % 3 == 2) ? 2'b10 : 2'b00;
        checks++;
        if (bus.out_flit !== 19'('h101 + n) || bus.out_type !== expT) begin
          errors++; $display("FAIL stall_drain flit%0d got %h/%b exp %h/%b", n, bus.out_flit, bus.out_type, 19'('h101 + n), expT);
        end
        n++;
      end
      tick();
    end
    checks++;
    if (n != 15 || bus.fifo_count !== 3'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_done got n %0d cnt %0d vld %b exp 15 0 0", n, bus.fifo_count, bus.out_valid);
    end
  endtask

  task automatic test_random();
    logic [FLIT_W-1:0] expFlit [$];
    logic [1:0]        expType [$];
    logic [63:0]       r;
    logic [FLIT_W-1:0] prevFlit, ef;
    logic [1:0]        prevType, et;
    bit inAcc, outAcc, prevStall;
    int sent, outN, cyc, shown;
    sent = 0; outN = 0; cyc = 0; shown = 0; prevStall = 0;
    prevFlit = '0; prevType = '0;
    bus.in_valid = 1'b0;
    while (outN < 3000 && cyc < 20000) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (!bus.in_valid && sent < 1000 && $urandom_range(0, 1) == 1) begin
        r = {$urandom, $urandom};
        bus.in_valid = 1'b1;
        bus.in_data  = r[PKT_W-1:0];
      end
      if (prevStall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_flit !== prevFlit || bus.out_type !== prevType) begin
          errors++; if (shown++ < 10) $display("FAIL rand_stall_stable got %h/%b exp %h/%b", bus.out_flit, bus.out_type, prevFlit, prevType);
        end
      end
      inAcc  = bus.in_valid && bus.in_ready;
      outAcc = bus.out_valid && bus.out_ready;
      if (inAcc) begin
        expFlit.push_back(bus.in_data[18:0]);  expType.push_back(2'b01);
        expFlit.push_back(bus.in_data[37:19]); expType.push_back(2'b00);
        expFlit.push_back(bus.in_data[56:38]); expType.push_back(2'b10);
        sent++;
      end
      if (outAcc) begin
        checks++;
        if (expFlit.size() == 0) begin
          errors++; if (shown++ < 10) $display("FAIL rand_extra_flit got %h exp none", bus.out_flit);
        end else begin
          ef = expFlit.pop_front();
          et = expType.pop_front();
          if (bus.out_flit !== ef || bus.out_type !== et) begin
            errors++; if (shown++ < 10) $display("FAIL rand_flit%0d got %h/%b exp %h/%b", outN, bus.out_flit, bus.out_type, ef, et);
          end
        end
        outN++;
      end
      prevStall = bus.out_valid && !bus.out_ready;
      prevFlit  = bus.out_flit;
      prevType  = bus.out_type;
      tick();
      cyc++;
      if (inAcc) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (outN != 3000 || sent != 1000 || expFlit.size() != 0) begin
      errors++; $display("FAIL rand_totals got flits %0d pkts %0d left %0d exp 3000 1000 0", outN, sent, expFlit.size());
    end
  endtask

  task automatic test_reset_mid();
    bit sawValid;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = {19'h0AAAA, 19'h0BBBB, 19'h0CCCC};
    tick();
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.out_type !== 2'b01 || bus.out_flit !== 19'h0CCCC) begin
      errors++; $display("FAIL rmid_head got %b/%h exp 01/0cccc", bus.out_type, bus.out_flit);
    end
    tick();
    checks++;
    if (bus.out_type !== 2'b00 || bus.out_flit !== 19'h0BBBB) begin
      errors++; $display("FAIL rmid_body got %b/%h exp 00/0bbbb", bus.out_type, bus.out_flit);
    end
    tick();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_type !== 2'b00 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rmid_reset got vld %b type %b busy %b exp 0 00 0", bus.out_valid, bus.out_type, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.out_valid) sawValid = 1;
    end
    checks++;
    if (sawValid || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_no_tail got sawValid %b rdy %b exp 0 1", sawValid, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = {19'h00033, 19'h00022, 19'h00011};
    tick();
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_type !== 2'b01 || bus.out_flit !== 19'h00011) begin
      errors++; $display("FAIL rmid_next_head got %b/%b/%h exp 1/01/00011", bus.out_valid, bus.out_type, bus.out_flit);
    end
    repeat (3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
